// File: rtl/visited_path_store_pkg.sv
// Shared constants and walker state encoding for visited_path_store.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package visited_path_store_pkg;

    // Default node capacity and index width; MAX_NODES must stay below 2**INDEX_WIDTH
    // so that the all-ones index is free to mean "unvisited".
    localparam int DEFAULT_MAX_NODES   = 16;
    localparam int DEFAULT_INDEX_WIDTH = 5;

    // Backtrack walker states.
    typedef enum logic [1:0] {
        WALK_IDLE  = 2'd0,
        WALK_CHECK = 2'd1,
        WALK_EMIT  = 2'd2
    } walk_state_e;

endpackage

// File: rtl/visited_path_store_visit_arbiter.sv
// Per-cycle visit-write arbitration: range check, dedup across ports, newly-visited count.
// Latency: purely combinational.
// Backpressure: none; dropped writes are reported through commit_o/range_err_o.
//
// Ports:
//   set_en_i/set_index_i : raw per-port visit requests (port p at bits [p*W +: W])
//   num_nodes_i          : node count captured at reset
//   visited_i            : current visited flag per node
//   commit_o             : port p must write its entry this cycle
//   range_err_o          : some enabled port carried an index >= node count
//   new_count_o          : number of distinct nodes newly visited this cycle
module visited_path_store_visit_arbiter
    import visited_path_store_pkg::*;
#(
    parameter int MAX_NODES   = DEFAULT_MAX_NODES,
    parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
    parameter int NUM_PORTS   = 2,
    parameter int CNT_WIDTH   = $clog2(NUM_PORTS + 1)
) (
    input  logic [NUM_PORTS-1:0]             set_en_i,
    input  logic [INDEX_WIDTH*NUM_PORTS-1:0] set_index_i,
    input  logic [INDEX_WIDTH-1:0]           num_nodes_i,
    input  logic [MAX_NODES-1:0]             visited_i,
    output logic [NUM_PORTS-1:0]             commit_o,
    output logic                             range_err_o,
    output logic [CNT_WIDTH-1:0]             new_count_o
);

    logic [INDEX_WIDTH-1:0] idx [NUM_PORTS];
    logic [NUM_PORTS-1:0]   in_range;
    logic [NUM_PORTS-1:0]   already;
    logic [NUM_PORTS-1:0]   shadowed;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            idx[p] = set_index_i[p*INDEX_WIDTH +: INDEX_WIDTH];
        end
    end

    always_comb begin
        in_range    = '0;
        already     = '0;
        shadowed    = '0;
        commit_o    = '0;
        range_err_o = 1'b0;
        new_count_o = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            // The array bound is checked too, so a node count larger than the
            // capacity can never steer a write outside the table.
            in_range[p] = (idx[p] < num_nodes_i) && (int'(idx[p]) < MAX_NODES);
            for (int i = 0; i < MAX_NODES; i++) begin
                if (idx[p] == INDEX_WIDTH'(i)) begin
                    already[p] = visited_i[i];
                end
            end
            // A lower-numbered port hitting the same node takes precedence, which
            // also keeps the visited count from double-counting that node.
            for (int q = 0; q < p; q++) begin
                if (set_en_i[q] && in_range[q] && (idx[q] == idx[p])) begin
                    shadowed[p] = 1'b1;
                end
            end
            commit_o[p] = set_en_i[p] && in_range[p] && !already[p] && !shadowed[p];
            if (set_en_i[p] && !in_range[p]) begin
                range_err_o = 1'b1;
            end
            new_count_o = new_count_o + CNT_WIDTH'(commit_o[p]);
        end
    end

endmodule

// File: rtl/visited_path_store.sv
// Multi-port visited/predecessor store with a backtrack path walker.
// Latency: writes/queries 1 cycle; walk_start -> first walk_valid or walk_error 2 cycles.
// Backpressure: walk_node/walk_last held while walk_valid && !walk_ready; writes never stall.
//
// Ports:
//   clock/reset                     : posedge clock, synchronous active-high reset
//   number_of_nodes/source_node     : captured while reset is high
//   set_en/set_index/set_prev       : NUM_PORTS visit writes, first visit wins
//   query_index -> query_prev/_visited : registered random read
//   unvisited_nodes/all_visited     : count of nodes still unvisited
//   set_error                       : sticky out-of-range write flag
//   walk_*                          : backtrack walker, valid/ready stream target -> source
module visited_path_store
    import visited_path_store_pkg::*;
#(
    parameter int MAX_NODES   = DEFAULT_MAX_NODES,
    parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
    parameter int NUM_PORTS   = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [INDEX_WIDTH-1:0]           number_of_nodes,
    input  logic [INDEX_WIDTH-1:0]           source_node,
    input  logic [NUM_PORTS-1:0]             set_en,
    input  logic [INDEX_WIDTH*NUM_PORTS-1:0] set_index,
    input  logic [INDEX_WIDTH*NUM_PORTS-1:0] set_prev,
    input  logic [INDEX_WIDTH-1:0]           query_index,
    output logic [INDEX_WIDTH-1:0]           query_prev,
    output logic                             query_visited,
    output logic [INDEX_WIDTH-1:0]           unvisited_nodes,
    output logic                             all_visited,
    output logic                             set_error,
    input  logic                             walk_start,
    input  logic [INDEX_WIDTH-1:0]           walk_target,
    output logic [INDEX_WIDTH-1:0]           walk_node,
    output logic                             walk_valid,
    input  logic                             walk_ready,
    output logic                             walk_last,
    output logic                             walk_busy,
    output logic                             walk_error
);

    localparam int CNT_WIDTH  = $clog2(NUM_PORTS + 1);
    localparam int STEP_WIDTH = $clog2(MAX_NODES + 1);
    localparam logic [INDEX_WIDTH-1:0] UNVISITED = '1;

    logic [INDEX_WIDTH-1:0] prev_q [MAX_NODES];
    logic [INDEX_WIDTH-1:0] prev_d [MAX_NODES];
    logic [INDEX_WIDTH-1:0] num_nodes_q;
    logic [INDEX_WIDTH-1:0] unvisited_q, unvisited_d;
    logic                   set_error_q, set_error_d;
    logic [INDEX_WIDTH-1:0] query_prev_q;
    logic                   query_visited_q;

    walk_state_e            state_q, state_d;
    logic [INDEX_WIDTH-1:0] node_q, node_d;
    logic [STEP_WIDTH-1:0]  step_q, step_d;
    logic                   walk_error_q, walk_error_d;

    logic [MAX_NODES-1:0]   visited;
    logic [NUM_PORTS-1:0]   commit;
    logic                   range_err;
    logic [CNT_WIDTH-1:0]   new_count;
    logic [INDEX_WIDTH-1:0] node_prev;
    logic [INDEX_WIDTH-1:0] query_rd;
    logic                   node_ok;
    logic                   prev_ok;

    visited_path_store_visit_arbiter #(
        .MAX_NODES   (MAX_NODES),
        .INDEX_WIDTH (INDEX_WIDTH),
        .NUM_PORTS   (NUM_PORTS),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_visit_arbiter (
        .set_en_i    (set_en),
        .set_index_i (set_index),
        .num_nodes_i (num_nodes_q),
        .visited_i   (visited),
        .commit_o    (commit),
        .range_err_o (range_err),
        .new_count_o (new_count)
    );

    // Table reads. An index outside the table reads back as UNVISITED.
    always_comb begin
        node_prev = UNVISITED;
        query_rd  = UNVISITED;
        for (int i = 0; i < MAX_NODES; i++) begin
            visited[i] = (prev_q[i] != UNVISITED);
            if (node_q == INDEX_WIDTH'(i)) begin
                node_prev = prev_q[i];
            end
            if (query_index == INDEX_WIDTH'(i)) begin
                query_rd = prev_q[i];
            end
        end
        node_ok = (int'(node_q) < MAX_NODES) && (node_q < num_nodes_q);
        prev_ok = (int'(node_prev) < MAX_NODES) && (node_prev < num_nodes_q);
    end

    // Visit writes and bookkeeping.
    always_comb begin
        prev_d = prev_q;
        for (int i = 0; i < MAX_NODES; i++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (commit[p] && (set_index[p*INDEX_WIDTH +: INDEX_WIDTH] == INDEX_WIDTH'(i))) begin
                    prev_d[i] = set_prev[p*INDEX_WIDTH +: INDEX_WIDTH];
                end
            end
        end
        unvisited_d = (unvisited_q > INDEX_WIDTH'(new_count)) ?
                      (unvisited_q - INDEX_WIDTH'(new_count)) : '0;
        set_error_d = set_error_q | range_err;
    end

    // Walker next state and stream outputs.
    always_comb begin
        state_d      = state_q;
        node_d       = node_q;
        step_d       = step_q;
        walk_error_d = 1'b0;
        walk_valid   = 1'b0;
        walk_last    = 1'b0;
        case (state_q)
            WALK_IDLE: begin
                if (walk_start) begin
                    state_d = WALK_CHECK;
                    node_d  = walk_target;
                    step_d  = '0;
                end
            end
            WALK_CHECK: begin
                if (!node_ok || (node_prev == UNVISITED)) begin
                    walk_error_d = 1'b1;
                    state_d      = WALK_IDLE;
                end else begin
                    state_d = WALK_EMIT;
                end
            end
            WALK_EMIT: begin
                walk_valid = 1'b1;
                walk_last  = (node_prev == node_q);
                if (walk_ready) begin
                    if (walk_last) begin
                        state_d = WALK_IDLE;
                    end else if ((step_q == STEP_WIDTH'(MAX_NODES - 1)) || !prev_ok) begin
                        // Either the chain never reaches the source within the
                        // node capacity, or it points outside the graph: both
                        // mean the table is corrupt.
                        walk_error_d = 1'b1;
                        state_d      = WALK_IDLE;
                    end else begin
                        node_d = node_prev;
                        step_d = step_q + STEP_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = WALK_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < MAX_NODES; i++) begin
                prev_q[i] <= (source_node == INDEX_WIDTH'(i)) ? source_node : UNVISITED;
            end
            num_nodes_q     <= number_of_nodes;
            unvisited_q     <= (number_of_nodes == '0) ? '0 : (number_of_nodes - INDEX_WIDTH'(1));
            set_error_q     <= 1'b0;
            query_prev_q    <= '0;
            query_visited_q <= 1'b0;
            state_q         <= WALK_IDLE;
            node_q          <= '0;
            step_q          <= '0;
            walk_error_q    <= 1'b0;
        end else begin
            prev_q          <= prev_d;
            unvisited_q     <= unvisited_d;
            set_error_q     <= set_error_d;
            query_prev_q    <= query_rd;
            query_visited_q <= (query_rd != UNVISITED);
            state_q         <= state_d;
            node_q          <= node_d;
            step_q          <= step_d;
            walk_error_q    <= walk_error_d;
        end
    end

    assign query_prev      = query_prev_q;
    assign query_visited   = query_visited_q;
    assign unvisited_nodes = unvisited_q;
    assign all_visited     = (unvisited_q == '0);
    assign set_error       = set_error_q;
    assign walk_node       = node_q;
    assign walk_busy       = (state_q != WALK_IDLE);
    assign walk_error      = walk_error_q;

endmodule

// File: tb/tb_visited_path_store.sv
module tb_visited_path_store;

    localparam int MAXN = 16;
    localparam int W    = 5;
    localparam int NP   = 2;
    localparam int UNV  = (1 << W) - 1;

    logic              clock = 1'b0;
    logic              reset;
    logic [W-1:0]      number_of_nodes;
    logic [W-1:0]      source_node;
    logic [NP-1:0]     set_en;
    logic [W*NP-1:0]   set_index;
    logic [W*NP-1:0]   set_prev;
    logic [W-1:0]      query_index;
    logic [W-1:0]      query_prev;
    logic              query_visited;
    logic [W-1:0]      unvisited_nodes;
    logic              all_visited;
    logic              set_error;
    logic              walk_start;
    logic [W-1:0]      walk_target;
    logic [W-1:0]      walk_node;
    logic              walk_valid;
    logic              walk_ready;
    logic              walk_last;
    logic              walk_busy;
    logic              walk_error;

    always #5 clock = ~clock;

    visited_path_store #(
        .MAX_NODES   (MAXN),
        .INDEX_WIDTH (W),
        .NUM_PORTS   (NP)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .number_of_nodes (number_of_nodes),
        .source_node     (source_node),
        .set_en          (set_en),
        .set_index       (set_index),
        .set_prev        (set_prev),
        .query_index     (query_index),
        .query_prev      (query_prev),
        .query_visited   (query_visited),
        .unvisited_nodes (unvisited_nodes),
        .all_visited     (all_visited),
        .set_error       (set_error),
        .walk_start      (walk_start),
        .walk_target     (walk_target),
        .walk_node       (walk_node),
        .walk_valid      (walk_valid),
        .walk_ready      (walk_ready),
        .walk_last       (walk_last),
        .walk_busy       (walk_busy),
        .walk_error      (walk_error)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: predecessor per node (-1 = unvisited), node count,
    // unvisited count and sticky error flag.
    int mprev [MAXN];
    int mn;
    int munv;
    bit merr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int mread(input int idx);
        if (idx < MAXN && mprev[idx] >= 0) return mprev[idx];
        return UNV;
    endfunction

    task automatic model_reset(input int n, input int src);
        for (int i = 0; i < MAXN; i++) mprev[i] = -1;
        mprev[src] = src;
        mn   = n;
        munv = n - 1;
        merr = 1'b0;
    endtask

    task automatic do_reset(input int n, input int src);
        reset           = 1'b1;
        number_of_nodes = W'(n);
        source_node     = W'(src);
        set_en          = '0;
        set_index       = '0;
        set_prev        = '0;
        query_index     = '0;
        walk_start      = 1'b0;
        walk_target     = '0;
        walk_ready      = 1'b0;
        tick();
        check("rst_query_prev", 32'(query_prev), 0);
        check("rst_query_visited", 32'(query_visited), 0);
        check("rst_walk_valid", 32'(walk_valid), 0);
        check("rst_walk_busy", 32'(walk_busy), 0);
        check("rst_walk_error", 32'(walk_error), 0);
        check("rst_set_error", 32'(set_error), 0);
        check("rst_unvisited", 32'(unvisited_nodes), n - 1);
        reset = 1'b0;
        model_reset(n, src);
    endtask

    // One clock of visit writes plus a query, checked against the model.
    task automatic cycle(input bit [NP-1:0] en, input int i0, input int p0,
                         input int i1, input int p1, input int q);
        int ia [NP];
        int pa [NP];
        int eprev;
        ia[0] = i0; ia[1] = i1;
        pa[0] = p0; pa[1] = p1;
        set_en      = en;
        set_index   = {W'(i1), W'(i0)};
        set_prev    = {W'(p1), W'(p0)};
        query_index = W'(q);
        eprev       = mread(q);   // query sees the table as it was before this cycle's writes
        tick();
        set_en = '0;
        // Ports applied in order: the first writer of a node wins.
        for (int p = 0; p < NP; p++) begin
            if (en[p]) begin
                if (ia[p] >= mn) merr = 1'b1;
                else if (mprev[ia[p]] < 0) begin
                    mprev[ia[p]] = pa[p];
                    if (munv > 0) munv--;
                end
            end
        end
        check("query_prev", 32'(query_prev), eprev);
        check("query_visited", 32'(query_visited), (eprev != UNV) ? 1 : 0);
        check("unvisited_nodes", 32'(unvisited_nodes), munv);
        check("all_visited", 32'(all_visited), (munv == 0) ? 1 : 0);
        check("set_error", 32'(set_error), merr ? 1 : 0);
    endtask

    // mode 0: ready always high, 1: ready toggles 1,0, 2: random ready.
    task automatic walk(input int target, input int mode);
        int  path [$];
        bit  corrupt;
        bit  bad;
        int  p;
        int  idx;
        bit  rdy;
        bit  tog;
        corrupt = 1'b0;
        bad     = (target >= mn) || (mread(target) == UNV);
        if (!bad) begin
            p       = target;
            corrupt = 1'b1;
            for (int k = 0; k < MAXN; k++) begin
                path.push_back(p);
                if (mprev[p] == p) begin
                    corrupt = 1'b0;
                    break;
                end
                p = mprev[p];
            end
        end
        walk_start  = 1'b1;
        walk_target = W'(target);
        walk_ready  = 1'b0;
        tick();
        walk_start = 1'b0;
        check("walk_check_busy", 32'(walk_busy), 1);
        check("walk_check_valid", 32'(walk_valid), 0);
        tick();
        if (bad) begin
            check("walk_bad_error", 32'(walk_error), 1);
            check("walk_bad_valid", 32'(walk_valid), 0);
            tick();
            check("walk_bad_error_pulse", 32'(walk_error), 0);
            check("walk_bad_busy", 32'(walk_busy), 0);
        end else begin
            idx = 0;
            tog = 1'b1;
            for (int c = 0; c < 200; c++) begin
                if (idx == path.size()) break;
                check("walk_valid", 32'(walk_valid), 1);
                check("walk_node", 32'(walk_node), path[idx]);
                check("walk_last", 32'(walk_last), (!corrupt && idx == path.size() - 1) ? 1 : 0);
                check("walk_error_mid", 32'(walk_error), 0);
                case (mode)
                    0:       rdy = 1'b1;
                    1:       begin rdy = tog; tog = ~tog; end
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                walk_ready = rdy;
                tick();
                if (rdy) idx++;
            end
            walk_ready = 1'b0;
            check("walk_timeout", idx, path.size());
            check("walk_end_valid", 32'(walk_valid), 0);
            check("walk_end_error", 32'(walk_error), corrupt ? 1 : 0);
            check("walk_end_busy", 32'(walk_busy), 0);
        end
    endtask

    task automatic random_round();
        int vis [$];
        bit [NP-1:0] en;
        int n, src, i0, i1, p0, p1, q;
        n   = $urandom_range(2, MAXN);
        src = $urandom_range(0, n - 1);
        do_reset(n, src);
        for (int c = 0; c < 60; c++) begin
            vis = {};
            for (int k = 0; k < mn; k++) if (mprev[k] >= 0) vis.push_back(k);
            en = NP'($urandom_range(0, 3));
            i0 = $urandom_range(0, mn + 3);
            i1 = ($urandom_range(0, 3) == 0) ? i0 : int'($urandom_range(0, mn + 3));
            // Predecessors are already-visited nodes, so every chain ends at the source.
            p0 = vis[$urandom_range(0, vis.size() - 1)];
            p1 = vis[$urandom_range(0, vis.size() - 1)];
            q  = $urandom_range(0, mn + 2);
            cycle(en, i0, p0, i1, p1, q);
        end
        for (int w = 0; w < 4; w++) begin
            walk($urandom_range(0, mn - 1), 2);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        // Reset state and basic queries.
        do_reset(5, 0);
        cycle(2'b00, 0, 0, 0, 0, 0);
        cycle(2'b00, 0, 0, 0, 0, 3);

        // Walk to an unvisited target.
        walk(2, 0);

        // Same node on both ports: port 0 wins, counted once; query of the
        // node written this cycle still returns the old value.
        cycle(2'b11, 2, 0, 2, 1, 2);
        cycle(2'b01, 2, 4, 0, 0, 2);

        // Out-of-range write.
        cycle(2'b01, 7, 0, 0, 0, 7);

        // Build chain 0 <- 1 <- 3 <- 4.
        cycle(2'b11, 1, 0, 3, 1, 1);
        cycle(2'b01, 4, 3, 0, 0, 4);
        cycle(2'b00, 0, 0, 0, 0, 3);

        walk(4, 0);
        walk(4, 1);
        walk(0, 0);

        // Reset while the walker is emitting.
        walk_start  = 1'b1;
        walk_target = W'(4);
        walk_ready  = 1'b0;
        tick();
        walk_start = 1'b0;
        tick();
        check("midwalk_valid_before", 32'(walk_valid), 1);
        reset = 1'b1;
        tick();
        check("midwalk_reset_valid", 32'(walk_valid), 0);
        check("midwalk_reset_busy", 32'(walk_busy), 0);
        reset = 1'b0;

        // Corrupt loop 1 <-> 2: walk gives up after MAXN nodes.
        do_reset(6, 0);
        cycle(2'b11, 1, 2, 2, 1, 1);
        walk(1, 0);

        // Randomized rounds against the model.
        for (int r = 0; r < 4; r++) random_round();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
